and_resp_checker: RTL

AND_RESP_CHECKER -- requirements
Module: and_resp_checker

---
 rtl/and_chk_pkg.sv | 23 ++
 rtl/chk_fifo.sv | 48 ++++
 rtl/and_resp_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/and_chk_pkg.sv
// Shared types for the AND/ADD response checker: FSM states, op encodings, sample record.
// Also holds the reference function used by the compare stage.
package and_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } sample_t;

  // Expected result at 4-bit width; the ADD carry is dropped.
  function automatic logic [3:0] expected_y(input logic op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (op == OP_ADD) ? sum[3:0] : (a & b);
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// Sample FIFO: push writes same cycle, pop_dat shows head combinationally, one-cycle pointer update.
// Pushes while full and pops while empty are ignored; callers gate on full/empty.
module chk_fifo
  import and_chk_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sample_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     pop_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/and_resp_checker.sv
// Checks a stream of {a,b,y} against y==a&b or y==(a+b)%16; counters settle 2 cycles after accept.
// in_ready drops when the FIFO is full or expect_n samples are taken; CHK_FIRST_FAIL_CAPTURE_EN adds ff_* ports.
module and_resp_checker
  import and_chk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sel,
  input  logic [CNT_W-1:0] expect_n,
  input  logic             in_valid,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [3:0]       in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [3:0]       ff_a,
  output logic [3:0]       ff_b,
  output logic [3:0]       ff_y,
  output logic [CNT_W-1:0] ff_idx
`endif
);

  chk_state_t       state;
  logic             op_q;
  logic [CNT_W-1:0] exp_n_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_nxt;
  logic             accept;
  logic             last_accept;
  logic             arm;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  sample_t          in_smp;
  sample_t          pop_dat;
  logic             cmp_vld;
  logic             cmp_ok;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] pop_idx;
  logic [CNT_W-1:0] cmp_idx;
  sample_t          cmp_smp;
  logic             ff_vld;
`endif

  assign in_smp      = '{a: in_a, b: in_b, y: in_y};
  assign in_ready    = (state == RUN) && !fifo_full && (acc_cnt < exp_n_q);
  assign accept      = in_valid && in_ready;
  assign acc_nxt     = acc_cnt + CNT_W'(1);
  assign last_accept = accept && (acc_nxt == exp_n_q);
  assign arm         = start && ((state == IDLE) || (state == DONE));
  assign pop         = !fifo_empty && ((state == RUN) || (state == DRAIN));

  chk_fifo #(
    .DEPTH (DEPTH),
    .T     (sample_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (in_smp),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      op_q    <= OP_AND;
      exp_n_q <= '0;
      acc_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= op_sel;
            exp_n_q <= expect_n;
            acc_cnt <= '0;
            if (expect_n == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) acc_cnt <= acc_nxt;
          if (last_accept) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && !cmp_vld) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_vld <= 1'b0;
      cmp_ok  <= 1'b0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      pop_idx <= '0;
      cmp_idx <= '0;
      cmp_smp <= '0;
`endif
    end else begin
      cmp_vld <= pop;
      if (pop) cmp_ok <= (pop_dat.y == expected_y(op_q, pop_dat.a, pop_dat.b));
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      // FIFO order matches accept order, so the pop ordinal is the accept index.
      if (arm)      pop_idx <= '0;
      else if (pop) pop_idx <= pop_idx + CNT_W'(1);
      if (pop) begin
        cmp_idx <= pop_idx;
        cmp_smp <= pop_dat;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || arm) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      ff_vld   <= 1'b0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_y     <= '0;
      ff_idx   <= '0;
`endif
    end else if (cmp_vld) begin
      if (cmp_ok) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        err <= 1'b1;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        if (!ff_vld) begin
          ff_vld <= 1'b1;
          ff_a   <= cmp_smp.a;
          ff_b   <= cmp_smp.b;
          ff_y   <= cmp_smp.y;
          ff_idx <= cmp_idx;
        end
`endif
      end
    end
  end

endmodule
